// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong bit-reverse to natural order reorder buffer
// Sits after the last SDF stage; frames enter bit-reversed and leave in natural bin order.
module fft_bitrev_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16,
  localparam int LOG_N = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG_N-1:0] do_index,
  output logic             do_last
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [LOG_N-1:0] LAST_ADDR = LOG_N'(N - 1);

  state_t             state, state_next;
  logic [LOG_N-1:0]   wr_cnt;
  logic               wr_bank;
  logic               wr_last;
  logic [LOG_N-1:0]   rd_cnt, rd_cnt_next;
  logic               rd_bank, rd_bank_next;
  logic               rd_issue;
  logic               rd_done;
  logic [1:0]         full, full_next;
  logic [2*WIDTH-1:0] mem [2][N];
  logic [2*WIDTH-1:0] rd_data;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) begin
      r[i] = a[LOG_N-1-i];
    end
    return r;
  endfunction

  assign wr_last = di_en && (wr_cnt == LAST_ADDR);

  // Scattering writes to bitrev(wr_cnt) lets the reader simply count upward.
  always_ff @(posedge clock) begin
    if (di_en) begin
      mem[wr_bank][bitrev(wr_cnt)] <= {di_re, di_im};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (di_en) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      state   <= state_next;
      rd_cnt  <= rd_cnt_next;
      rd_bank <= rd_bank_next;
      full    <= full_next;
    end
  end

  always_comb begin
    state_next   = state;
    rd_cnt_next  = rd_cnt;
    rd_bank_next = rd_bank;
    rd_issue     = 1'b0;
    rd_done      = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_next  = READ;
          rd_cnt_next = '0;
        end
      end
      READ: begin
        rd_issue    = 1'b1;
        rd_cnt_next = rd_cnt + 1'b1;
        if (rd_cnt == LAST_ADDR) begin
          rd_done      = 1'b1;
          rd_bank_next = ~rd_bank;
          // Stay in READ when the other bank is waiting so frames abut.
          if (!full[~rd_bank]) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear first so a coincident set on the same flag wins.
  always_comb begin
    full_next = full;
    if (rd_done) begin
      full_next[rd_bank] = 1'b0;
    end
    if (wr_last) begin
      full_next[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      do_en    <= 1'b0;
      do_index <= '0;
      do_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      do_en    <= rd_issue;
      do_index <= rd_cnt;
      do_last  <= rd_issue && (rd_cnt == LAST_ADDR);
      if (rd_issue) begin
        rd_data <= mem[rd_bank][rd_cnt];
      end
    end
  end

  assign do_re = rd_data[2*WIDTH-1:WIDTH];
  assign do_im = rd_data[WIDTH-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - scoreboard bench for fft_bitrev_reorder (N=64 and N=16)
// A natural-order spectrum is presented bit-reversed; the same spectrum must return in order.
module tb_fft_bitrev_reorder;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          idx;
    bit          last;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        di_en = 1'b0;
  logic [15:0] di_re = '0, di_im = '0;
  logic        do_en, do_last;
  logic [15:0] do_re, do_im;
  logic [5:0]  do_index;

  logic        s_di_en = 1'b0;
  logic [15:0] s_di_re = '0, s_di_im = '0;
  logic        s_do_en, s_do_last;
  logic [15:0] s_do_re, s_do_im;
  logic [3:0]  s_do_index;

  int   cyc = 0;
  int   checks = 0, passes = 0;
  int   overflow_cnt = 0;
  int   prev_start = -1000;
  exp_t q64[$];
  exp_t q16[$];
  logic [15:0] spec_re [64];
  logic [15:0] spec_im [64];

  fft_bitrev_reorder #(.N(64), .WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im),
    .do_index(do_index), .do_last(do_last)
  );

  fft_bitrev_reorder #(.N(16), .WIDTH(16)) dut16 (
    .clock(clock), .reset(reset),
    .di_en(s_di_en), .di_re(s_di_re), .di_im(s_di_im),
    .do_en(s_do_en), .do_re(s_do_re), .do_im(s_do_im),
    .do_index(s_do_index), .do_last(s_do_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    else passes++;
  endtask

  // A write may only land in a full bank on the very edge its last address is being read.
  always @(negedge clock) begin
    if (!reset && di_en && dut.full[dut.wr_bank] &&
        !(dut.rd_issue && dut.rd_bank == dut.wr_bank && dut.rd_cnt == 6'd63))
      overflow_cnt++;
  end

  always @(negedge clock) begin
    exp_t e;
    if (do_en) begin
      checks++;
      if (q64.size() == 0) begin
        $display("FAIL out64 unexpected: actual index=%0d re=%0d, expected no output", do_index, do_re);
      end else begin
        e = q64.pop_front();
        if (do_re !== e.re || do_im !== e.im || int'(do_index) != e.idx || do_last !== e.last || cyc != e.cyc)
          $display("FAIL out64: actual re=%0d im=%0d index=%0d last=%0d cycle=%0d, expected re=%0d im=%0d index=%0d last=%0d cycle=%0d",
                   do_re, $signed(do_im), do_index, do_last, cyc, e.re, $signed(e.im), e.idx, e.last, e.cyc);
        else passes++;
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (s_do_en) begin
      checks++;
      if (q16.size() == 0) begin
        $display("FAIL out16 unexpected: actual index=%0d re=%0d, expected no output", s_do_index, s_do_re);
      end else begin
        e = q16.pop_front();
        if (s_do_re !== e.re || s_do_im !== e.im || int'(s_do_index) != e.idx || s_do_last !== e.last || cyc != e.cyc)
          $display("FAIL out16: actual re=%0d im=%0d index=%0d last=%0d cycle=%0d, expected re=%0d im=%0d index=%0d last=%0d cycle=%0d",
                   s_do_re, s_do_im, s_do_index, s_do_last, cyc, e.re, e.im, e.idx, e.last, e.cyc);
        else passes++;
      end
    end
  end

  task automatic fill_spec(input bit rnd, input int off);
    for (int i = 0; i < 64; i++) begin
      spec_re[i] = rnd ? 16'($urandom) : 16'(i + off);
      spec_im[i] = rnd ? 16'($urandom) : 16'(-(i + off));
    end
  endtask

  // Present spec[] bit-reversed; on completion the natural-order spectrum is expected.
  task automatic run_frame(input int gap_at, input int gap_len, input int abort_at);
    exp_t e;
    int   t_last, start;
    for (int k = 0; k < 64; k++) begin
      if (k == abort_at) begin
        di_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        q64.delete();
        prev_start = -1000;
        return;
      end
      di_en = 1'b1;
      di_re = spec_re[brev(k, 6)];
      di_im = spec_im[brev(k, 6)];
      @(posedge clock); #1;
      if (k == gap_at) begin
        di_en = 1'b0;
        repeat (gap_len) @(posedge clock);
        #1;
      end
    end
    di_en  = 1'b0;
    t_last = cyc;
    start  = (t_last + 2 > prev_start + 64) ? t_last + 2 : prev_start + 64;
    prev_start = start;
    for (int i = 0; i < 64; i++) begin
      e.re = spec_re[i]; e.im = spec_im[i]; e.idx = i; e.last = (i == 63); e.cyc = start + i;
      q64.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 600 && (q64.size() != 0 || q16.size() != 0); c++) @(posedge clock);
    repeat (20) @(posedge clock);
    #1;
    chk(name, q64.size() + q16.size(), 0);
  endtask

  initial begin
    exp_t e;
    int   t_last, gap_at, gap_len;
    bit   found;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_do_en", do_en, 0);
    chk("reset_do_re", do_re, 0);
    chk("reset_do_im", do_im, 0);
    chk("reset_do_index", do_index, 0);
    chk("reset_do_last", do_last, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    fill_spec(0, 0);
    run_frame(-1, 0, -1);
    drain("drain_single");

    for (int f = 0; f < 3; f++) begin
      fill_spec(0, f * 100);
      run_frame(-1, 0, -1);
    end
    drain("drain_back_to_back");

    fill_spec(0, 0);
    run_frame(20, 5, -1);
    drain("drain_gapped");

    for (int f = 0; f < 4; f++) begin
      fill_spec(1, 0);
      gap_at  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 62) : -1;
      gap_len = $urandom_range(1, 8);
      run_frame(gap_at, gap_len, -1);
    end
    drain("drain_random");

    fill_spec(1, 0);
    run_frame(-1, 0, 30);
    fill_spec(0, 1000);
    run_frame(-1, 0, -1);
    drain("drain_after_input_reset");

    fill_spec(1, 0);
    run_frame(-1, 0, -1);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clock);
      if (do_en && do_index == 6'd10) found = 1'b1;
    end
    chk("readout_reached_index10", found, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("midread_do_en", do_en, 0);
    chk("midread_do_re", do_re, 0);
    chk("midread_do_im", do_im, 0);
    chk("midread_do_index", do_index, 0);
    chk("midread_do_last", do_last, 0);
    q64.delete();
    prev_start = -1000;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    fill_spec(1, 0);
    run_frame(-1, 0, -1);
    drain("drain_after_read_reset");

    for (int k = 0; k < 16; k++) begin
      s_di_en = 1'b1;
      s_di_re = 16'(brev(k, 4));
      s_di_im = 16'(3 * brev(k, 4));
      @(posedge clock); #1;
    end
    s_di_en = 1'b0;
    t_last  = cyc;
    for (int i = 0; i < 16; i++) begin
      e.re = 16'(i); e.im = 16'(3 * i); e.idx = i; e.last = (i == 15); e.cyc = t_last + 2 + i;
      q16.push_back(e);
    end
    drain("drain_n16");

    chk("no_write_into_full_bank", overflow_cnt, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the 64-point radix-2^2 SDF FFT pipeline. It sits directly after the last SDF stage, takes its contiguous frames of N complex samples in bit-reversed bin order, and re-emits each frame in natural bin order (bin 0 first). It uses a two-bank ping-pong buffer, so back-to-back frames stream with no gaps.

## Interface

Parameters:
- N, default 64: FFT length. Power of two, ≥ 4. LOG_N = log2(N).
- WIDTH, default 16: width of each real/imag component (two's complement).

Ports:
- clock  in  1  master clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- di_en  in  1  input sample valid (last SDF stage do_en)
- di_re  in  WIDTH  input real part, bit-reversed frame order
- di_im  in  WIDTH  input imaginary part
- do_en  out  1  output sample valid
- do_re  out  WIDTH  output real part, natural order
- do_im  out  WIDTH  output imaginary part
- do_index  out  LOG_N  bin index of the current output sample
- do_last  out  1  high with bin N-1 of each output frame

## Operation

- Storage: two banks, each N × 2·WIDTH, with synchronous read. Each bank has a full flag (full[0], full[1]).
- Write side:
  - wr_cnt is LOG_N bits; wr_bank is 1 bit.
  - Each cycle with di_en=1, write {di_re, di_im} to bank wr_bank at address bitrev(wr_cnt), then increment wr_cnt.
  - di_en=0 holds wr_cnt. Gaps inside a frame are legal; the frame resumes where it stopped.
  - When a write occurs with wr_cnt = N-1: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
- Read side FSM has two states, IDLE and READ. Registers: rd_bank (1 bit), rd_cnt (LOG_N bits).
  - IDLE → READ when full[rd_bank]=1. rd_cnt=0.
  - READ: issue a read of bank rd_bank at address rd_cnt each cycle, then increment rd_cnt.
  - On issuing rd_cnt = N-1: clear full[rd_bank] and toggle rd_bank.
    - If the new bank is already full, stay in READ with rd_cnt=0 (no bubble).
    - Otherwise go to IDLE.
- Output registers: do_en, do_index and do_last are the read-issue valid, rd_cnt and (rd_cnt==N-1) delayed one cycle to align with RAM data. do_re and do_im are the RAM data.
- No overflow is possible. A bank needs ≥ N cycles to fill and exactly N cycles to drain, and the writer only enters a bank after it has been drained. The bench asserts that a write never targets a bank with full=1.
- Simultaneous set and clear of the same full flag cannot occur. If both are asserted on one edge, set wins.
- Output values are unmodified input samples. No scaling or rounding.

## Timing

- Reset values: do_en=0, do_re=0, do_im=0, do_index=0, do_last=0. Internally: wr_cnt=0, wr_bank=0, rd_bank=0, rd_cnt=0, full=00, FSM in IDLE. RAM contents are don't-care.
- Latency: let the last sample of a frame be captured at edge t.
  - full is set at edge t.
  - Read of address 0 is issued at edge t+1.
  - do_en=1 with do_index=0 becomes valid after edge t+2.
  - do_last=1 after edge t+N+1.
- do_en stays high for exactly N consecutive cycles per frame. Consecutive full frames produce continuous do_en.
- Reset asserted mid-frame or mid-readout: outputs go to reset values immediately (asynchronously). Partial or unread frames are discarded. After release, the first complete N-sample input frame is output normally with no stale data.
- Throughput: 1 sample/cycle sustained.

## Test plan

- Single frame: N=64, input k=0..63 with di_re=bitrev6(k), di_im=-bitrev6(k), di_en continuous → do_re=0..63 ascending, do_im=0..-63, do_index=i, do_last only at i=63, first do_en exactly 2 cycles after the last input edge.
- Three back-to-back frames with distinct offsets (0, 100, 200) → do_en high for 192 consecutive cycles, each frame correctly ordered, full-flag assertion never fires.
- Gapped input: same stimulus as the single-frame case but di_en low for 5 cycles after sample 20 → identical output values, output start 5 cycles later.
- Reset at input sample 30, release, then a full frame with di_re=bitrev6(k)+1000 → only 64 outputs, 1000..1063, no stale samples.
- Reset asserted during readout at do_index=10 → do_en, do_re, do_im and do_index read 0 immediately. The next frame outputs correctly from bin 0.
- Parameter N=16: input bitrev4(k) for k=0..15 → output 0..15 in order, do_last at index 15, latency 2 cycles.
